// File: rtl/e_mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Define MDU_DIV_EN to build the divider; without it div/divu are no-ops.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic [3:0]  MDUOp,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] MDUOut,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MFHI  = 4'd5,
      OP_MFLO  = 4'd6,
      OP_MTHI  = 4'd7,
      OP_MTLO  = 4'd8
   } mdu_op_e;

   typedef enum logic {S_IDLE, S_BUSY} state_e;

   localparam logic [31:0] MULT_N = (MULT_CYCLES < 1) ? 32'd1 : 32'(MULT_CYCLES);
   localparam logic [31:0] DIV_N  = (DIV_CYCLES  < 1) ? 32'd1 : 32'(DIV_CYCLES);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] stg_hi_q, stg_hi_d, stg_lo_q, stg_lo_d;
   logic        stg_wr_q, stg_wr_d;

   logic        long_op;
   logic        op_is_div;
   logic [63:0] prod_s, prod_u;

   always_comb begin
      prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
      prod_u = {32'd0, A} * {32'd0, B};
   end

`ifdef MDU_DIV_EN
   logic [31:0] div_b;
   logic [31:0] quo_s, rem_s, quo_u, rem_u;

   // Divisor forced to 1 on zero so the datapath never sees x; the result is discarded anyway.
   always_comb begin
      div_b = (B == 32'd0) ? 32'd1 : B;
      quo_u = A / div_b;
      rem_u = A % div_b;
      if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
         quo_s = 32'h8000_0000;
         rem_s = 32'd0;
      end else begin
         quo_s = 32'($signed(A) / $signed(div_b));
         rem_s = 32'($signed(A) % $signed(div_b));
      end
   end

   assign long_op = req && (MDUOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
`else
   assign long_op = req && (MDUOp inside {OP_MULT, OP_MULTU});
`endif

   assign op_is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
   assign busy      = (state_q == S_BUSY);
   assign stall_req = busy || long_op;
   assign HI        = hi_q;
   assign LO        = lo_q;

   always_comb begin
      case (MDUOp)
         OP_MFHI: MDUOut = hi_q;
         OP_MFLO: MDUOut = lo_q;
         default: MDUOut = 32'd0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      stg_hi_d = stg_hi_q;
      stg_lo_d = stg_lo_q;
      stg_wr_d = stg_wr_q;
      case (state_q)
         S_IDLE: begin
            if (long_op) begin
               state_d  = S_BUSY;
               cnt_d    = op_is_div ? DIV_N : MULT_N;
               stg_wr_d = 1'b1;
               case (MDUOp)
                  OP_MULT:  {stg_hi_d, stg_lo_d} = prod_s;
                  OP_MULTU: {stg_hi_d, stg_lo_d} = prod_u;
`ifdef MDU_DIV_EN
                  OP_DIV: begin
                     stg_hi_d = rem_s;
                     stg_lo_d = quo_s;
                     stg_wr_d = (B != 32'd0);
                  end
                  OP_DIVU: begin
                     stg_hi_d = rem_u;
                     stg_lo_d = quo_u;
                     stg_wr_d = (B != 32'd0);
                  end
`endif
                  default: stg_wr_d = 1'b0;
               endcase
            end else if (req && MDUOp == OP_MTHI) begin
               hi_d = A;
            end else if (req && MDUOp == OP_MTLO) begin
               lo_d = A;
            end
         end
         S_BUSY: begin
            // Requests are deliberately ignored here, including on the final edge.
            if (cnt_q == 32'd1) begin
               state_d = S_IDLE;
               cnt_d   = 32'd0;
               if (stg_wr_q) begin
                  hi_d = stg_hi_q;
                  lo_d = stg_lo_q;
               end
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         stg_hi_q <= 32'd0;
         stg_lo_q <= 32'd0;
         stg_wr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         stg_hi_q <= stg_hi_d;
         stg_lo_q <= stg_lo_d;
         stg_wr_q <= stg_wr_d;
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu; expectations follow MDU_DIV_EN when defined.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, stall_req;
   logic [31:0] mdu_out, hi, lo;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] m_hi, m_lo;

`ifdef MDU_DIV_EN
   localparam int DIVN = 10;
`else
   localparam int DIVN = 0;
`endif

   always #5 clk = ~clk;

   e_mdu dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .MDUOp    (op),
      .A        (a),
      .B        (b),
      .busy     (busy),
      .stall_req(stall_req),
      .MDUOut   (mdu_out),
      .HI       (hi),
      .LO       (lo)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input int n);
      req = 1'b1; op = o; a = x; b = y;
      #1;
      chk("stall_req", 32'(stall_req), (n > 0) ? 32'd1 : 32'd0);
      step();
      req = 1'b0; op = 4'd0;
      for (int i = 0; i < n; i++) begin
         chk("busy_on", 32'(busy), 32'd1);
         step();
      end
      chk("busy_off", 32'(busy), 32'd0);
      $display("txn op=%0d A=%h B=%h -> HI=%h LO=%h", o, x, y, hi, lo);
   endtask

   task automatic rd(input string tag, input logic [3:0] o, input logic [31:0] exp);
      op = o;
      #1;
      chk(tag, mdu_out, exp);
      op = 4'd0;
   endtask

   task automatic chk_hilo(input string tag);
      chk({tag, "_hi"}, hi, m_hi);
      chk({tag, "_lo"}, lo, m_lo);
   endtask

   initial begin
      // Reset state and combinational outputs while reset is held
      req = 1'b1; op = 4'd1;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_stall_mult", 32'(stall_req), 32'd1);
      op = 4'd3;
      #1;
      chk("rst_stall_div", 32'(stall_req), (DIVN > 0) ? 32'd1 : 32'd0);
      req = 1'b0;
      rd("rst_mfhi", 4'd5, 32'd0);
      step(); step();
      reset_n = 1'b1;
      step();

      run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 5);
      m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA; chk_hilo("mult");
      run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
      m_hi = 32'hFFFF_FFFE; m_lo = 32'h0000_0001; chk_hilo("multu");

      run_op(4'd7, 32'hA5A5_0001, 32'd0, 0);
      run_op(4'd8, 32'h0000_BEEF, 32'd0, 0);
      m_hi = 32'hA5A5_0001; m_lo = 32'h0000_BEEF; chk_hilo("mthi_mtlo");
      rd("mfhi", 4'd5, 32'hA5A5_0001);
      rd("mflo", 4'd6, 32'h0000_BEEF);
      rd("noop_out", 4'd9, 32'd0);

      run_op(4'd3, 32'hFFFF_FFF9, 32'd2, DIVN);
      if (DIVN > 0) begin m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD; end
      chk_hilo("div_neg7_2");
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DIVN);
      if (DIVN > 0) begin m_hi = 32'd0; m_lo = 32'h8000_0000; end
      chk_hilo("div_ovf");
      run_op(4'd4, 32'd7, 32'd0, DIVN);
      chk_hilo("divu_by0");
      run_op(4'd4, 32'd100, 32'd7, DIVN);
      if (DIVN > 0) begin m_hi = 32'd2; m_lo = 32'd14; end
      chk_hilo("divu_100_7");
      run_op(4'd3, 32'd7, 32'hFFFF_FFFE, DIVN);
      if (DIVN > 0) begin m_hi = 32'd1; m_lo = 32'hFFFF_FFFD; end
      chk_hilo("div_7_neg2");

      // Requests during a multiply, including on its final edge, must be ignored
      req = 1'b1; op = 4'd1; a = 32'd6; b = 32'd7;
      step();
      req = 1'b0;
      step();
      req = 1'b1; op = 4'd8; a = 32'h1234;
      step();
      op = 4'd1; a = 32'd2; b = 32'd2;
      step();
      req = 1'b0;
      step();
      chk("busy_last", 32'(busy), 32'd1);
      chk("stall_busy", 32'(stall_req), 32'd1);
      req = 1'b1; op = 4'd1; a = 32'd3; b = 32'd3;
      step();
      req = 1'b0; op = 4'd0;
      chk("ignored_busy", 32'(busy), 32'd0);
      m_hi = 32'd0; m_lo = 32'd42; chk_hilo("ignored");
      rd("mflo_42", 4'd6, 32'd42);
      $display("txn mult 6*7 with ignored mtlo/mult -> HI=%h LO=%h", hi, lo);
      run_op(4'd1, 32'd3, 32'd3, 5);
      m_lo = 32'd9; chk_hilo("accept_after");

      // Reset in the middle of a long operation
      req = 1'b1; op = (DIVN > 0) ? 4'd3 : 4'd1; a = 32'd100; b = 32'd7;
      step();
      req = 1'b0; op = 4'd0;
      step(); step();
      reset_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_stall", 32'(stall_req), 32'd0);
      m_hi = 32'd0; m_lo = 32'd0; chk_hilo("abort");
      rd("abort_mflo", 4'd6, 32'd0);
      step();
      reset_n = 1'b1;
      repeat (15) step();
      chk("post_abort_busy", 32'(busy), 32'd0);
      chk_hilo("post_abort");
      $display("txn reset abort -> HI=%h LO=%h", hi, lo);
      run_op(4'd7, 32'd5, 32'd0, 0);
      rd("mfhi_5", 4'd5, 32'd5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy duration of mult/multu.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy duration of div/divu.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  qualifies MDUOp for one cycle.
REQ-006 SHALL have port MDUOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 no-op.
REQ-007 SHALL have ports A, B  input  32 each  operands: A = rs/dividend, B = rt/divisor.
REQ-008 SHALL have port busy  output  1  registered, high while an operation is in flight.
REQ-009 SHALL have port stall_req  output  1  combinational busy OR (req AND MDUOp in 1-4), used by the hazard unit.
REQ-010 SHALL have port MDUOut  output  32  combinational read data.
REQ-011 SHALL have ports HI, LO  output  32 each  architectural registers, for debug/visibility.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and BUSY, plus a down-counter and two result staging registers.
REQ-013 In IDLE, req with op 1-4 at edge t SHALL capture the computed 64-bit result into staging, load the counter, and enter BUSY.
REQ-014 busy SHALL be 1 on cycles t+1 .. t+N, N = MULT_CYCLES or DIV_CYCLES.
REQ-015 HI/LO SHALL take the staged result at the edge ending cycle t+N: visible at t+N+1 together with busy=0 and state IDLE.
REQ-016 mult SHALL give {HI,LO} = signed 64-bit A*B; multu SHALL give the unsigned 64-bit product.
REQ-017 div/divu SHALL give LO = quotient, HI = remainder, signed or unsigned respectively.
REQ-018 Signed division SHALL truncate the quotient toward zero, with the remainder taking the sign of the dividend.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 Division by zero SHALL still hold busy for DIV_CYCLES and SHALL leave HI and LO unchanged.
REQ-021 In IDLE, req with mthi/mtlo SHALL write A into HI/LO at that edge; busy stays 0.
REQ-022 MDUOut SHALL be HI for mfhi, LO for mflo, else 0, independent of req and busy.
REQ-023 In BUSY, every req SHALL be ignored: no restart, no mthi/mtlo write, staging untouched.
REQ-024 Counter reaching 1 in BUSY SHALL return to IDLE at the next edge; a req on that same edge is still ignored, and a new op is accepted from t+N+1.
REQ-025 Back-to-back operations SHALL be sequenced by the hazard unit via stall_req; e_mdu holds no request queue.
REQ-026 A parameter value below 1 SHALL be treated as 1.

Reset
REQ-027 reset_n low SHALL immediately clear HI, LO, staging, counter, busy=0, state=IDLE, including mid-operation.
REQ-028 A result aborted by reset SHALL never appear in HI/LO.
REQ-029 With reset_n low, stall_req SHALL reflect only req/MDUOp; MDUOut SHALL read 0.

Configuration
REQ-030 Macro MDU_DIV_EN defined: div/divu SHALL be implemented as specified above.
REQ-031 Macro MDU_DIV_EN undefined: no divider logic SHALL be synthesized; MDUOp 3/4 SHALL be no-ops, busy=0, HI/LO unchanged, stall_req not asserted for them.

Verification
REQ-032 mult A=0xFFFFFFFE, B=3 -> busy cycles t+1..t+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-033 multu A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 at t+6.
REQ-034 div A=0xFFFFFFF9 (-7), B=2 -> 10 busy cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> HI/LO unchanged.
REQ-035 During mult busy, issue mtlo A=0x1234 and a second mult -> both ignored; final LO = first product; mflo reads it.
REQ-036 reset_n low at cycle t+3 of div -> busy=0 immediately, HI=LO=0, no later update; mthi A=5 then mfhi -> MDUOut=5.
